// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard sources coming in from the pipeline and the
// per-stage enable/flush controls going back out.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ifid_rs1;
    logic [4:0]       ifid_rs2;
    logic             ifid_use_rs1;
    logic             ifid_use_rs2;
    logic             idex_memread;
    logic [4:0]       idex_rd;
    logic             branch_taken;
    logic             exmem_mem_access;
    logic             mem_ready;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_en;
    logic             memwb_bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic             mem_err;

    // The pipeline datapath side.
    modport master (
        output ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
               idex_memread, idex_rd, branch_taken, exmem_mem_access, mem_ready,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, memwb_en, memwb_bubble, stall_cnt, mem_err
    );

    // The hazard controller side.
    modport slave (
        input  ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
               idex_memread, idex_rd, branch_taken, exmem_mem_access, mem_ready,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, memwb_en, memwb_bubble, stall_cnt, mem_err
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken-branch and
// multi-cycle memory hazards, plus a saturating stall counter and timeout flag.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  hz
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              mem_err_q, mem_err_d;

    logic load_use;
    logic mem_stall;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic exmem_en, memwb_en, memwb_bubble;

    assign load_use = hz.idex_memread && (hz.idex_rd != 5'd0) &&
                      ((hz.ifid_use_rs1 && (hz.idex_rd == hz.ifid_rs1)) ||
                       (hz.ifid_use_rs2 && (hz.idex_rd == hz.ifid_rs2)));

    assign mem_stall = hz.exmem_mem_access && !hz.mem_ready;

    // A memory stall freezes everything, so branch and load-use are simply
    // re-evaluated once the MEM instruction finally completes.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_flush   = 1'b0;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        memwb_bubble = 1'b0;
        if (!rst_n) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            ifid_flush   = 1'b1;
            idex_en      = 1'b0;
            idex_flush   = 1'b1;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (mem_stall) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (hz.branch_taken) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
        end else if (load_use) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_flush   = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                // Leaving also covers the access request dropping without ready.
                if (!mem_stall) begin
                    state_d = RUN;
                end else begin
                    if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                    if (wait_cnt_d == WAIT_MAX) begin
                        mem_err_d = 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.ifid_en      = ifid_en;
    assign hz.ifid_flush   = ifid_flush;
    assign hz.idex_en      = idex_en;
    assign hz.idex_flush   = idex_flush;
    assign hz.exmem_en     = exmem_en;
    assign hz.memwb_en     = memwb_en;
    assign hz.memwb_bubble = memwb_bubble;
    assign hz.stall_cnt    = stall_cnt_q;
    assign hz.mem_err      = mem_err_q;
endmodule
